// File: rtl/crop_sequencer.sv
// Crop controller: finds the bounding box of pixels below THRESH, then copies it packed row-major (CROP_HDR_COPY_EN adds a header copy pass).
// Latency: done after W*H + bw*bh + 2 cycles from start (W*H + 2 when empty), +HDR_BYTES with the header copy enabled.
// Backpressure: none; memories take one access per cycle with fixed 1-cycle read data, start is ignored while busy.
module crop_sequencer #(
   parameter int         IMG_W     = 8,
   parameter int         IMG_H     = 6,
   parameter int         ADDR_W    = 16,
   parameter int         HDR_BYTES = 4,
   parameter logic [7:0] THRESH    = 8'd128
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   output logic              src_rd,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [7:0]        src_data,
   output logic              dst_wr,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [7:0]        dst_data,
   output logic              busy,
   output logic              done,
   output logic              empty,
   output logic [15:0]       box_x0,
   output logic [15:0]       box_x1,
   output logic [15:0]       box_y0,
   output logic [15:0]       box_y1
);
   typedef enum logic [2:0] {
      S_IDLE,
`ifdef CROP_HDR_COPY_EN
      S_HDR,
`endif
      S_SCAN,
      S_SCAN_DRAIN,
      S_COPY,
      S_COPY_DRAIN,
      S_DONE
   } state_t;

   localparam logic [15:0]       X_LAST = 16'(IMG_W - 1);
   localparam logic [15:0]       Y_LAST = 16'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] HDR_A  = ADDR_W'(HDR_BYTES);

   state_t              state;
   logic [15:0]         cx, cy;
   logic                tag_vld;
   logic [15:0]         tag_x, tag_y;
   logic [ADDR_W-1:0]   tag_addr;
   logic                hit;
   logic [ADDR_W-1:0]   row_base;
   logic [ADDR_W-1:0]   dcnt;

   logic                fg, hit_n;
   logic [15:0]         x0_n, x1_n, y0_n, y1_n;
   logic [ADDR_W-1:0]   base_n;

   // Write data is the read data of the previous cycle, passed straight through.
   assign dst_data = dst_wr ? src_data : 8'h00;
   assign fg       = tag_vld && (src_data < THRESH);

   // Raster order means the first hit fixes y0 and the source row base of the box.
   always_comb begin
      hit_n  = hit;
      x0_n   = box_x0;
      x1_n   = box_x1;
      y0_n   = box_y0;
      y1_n   = box_y1;
      base_n = row_base;
      if (fg) begin
         if (!hit) begin
            hit_n  = 1'b1;
            x0_n   = tag_x;
            x1_n   = tag_x;
            y0_n   = tag_y;
            y1_n   = tag_y;
            base_n = tag_addr - ADDR_W'(tag_x);
         end else begin
            if (tag_x < box_x0) x0_n = tag_x;
            if (tag_x > box_x1) x1_n = tag_x;
            if (tag_y > box_y1) y1_n = tag_y;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         src_rd   <= 1'b0;
         src_addr <= '0;
         dst_wr   <= 1'b0;
         dst_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         empty    <= 1'b0;
         box_x0   <= '0;
         box_x1   <= '0;
         box_y0   <= '0;
         box_y1   <= '0;
         cx       <= '0;
         cy       <= '0;
         tag_vld  <= 1'b0;
         tag_x    <= '0;
         tag_y    <= '0;
         tag_addr <= '0;
         hit      <= 1'b0;
         row_base <= '0;
         dcnt     <= '0;
      end else begin
         tag_vld  <= 1'b0;
         dst_wr   <= 1'b0;
         hit      <= hit_n;
         box_x0   <= x0_n;
         box_x1   <= x1_n;
         box_y0   <= y0_n;
         box_y1   <= y1_n;
         row_base <= base_n;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  busy   <= 1'b1;
                  done   <= 1'b0;
                  empty  <= 1'b0;
                  hit    <= 1'b0;
                  box_x0 <= '0;
                  box_x1 <= '0;
                  box_y0 <= '0;
                  box_y1 <= '0;
                  cx     <= '0;
                  cy     <= '0;
                  dcnt   <= HDR_A;
                  src_rd <= 1'b1;
`ifdef CROP_HDR_COPY_EN
                  state    <= S_HDR;
                  src_addr <= '0;
`else
                  state    <= S_SCAN;
                  src_addr <= HDR_A;
`endif
               end
            end
`ifdef CROP_HDR_COPY_EN
            // Header bytes land at the same addresses; the increment rolls straight into the pixel array.
            S_HDR: begin
               dst_wr   <= 1'b1;
               dst_addr <= src_addr;
               src_addr <= src_addr + 1'b1;
               if (src_addr == HDR_A - 1'b1) state <= S_SCAN;
            end
`endif
            S_SCAN: begin
               tag_vld  <= 1'b1;
               tag_x    <= cx;
               tag_y    <= cy;
               tag_addr <= src_addr;
               src_addr <= src_addr + 1'b1;
               if (cx == X_LAST) begin
                  cx <= '0;
                  if (cy == Y_LAST) begin
                     src_rd <= 1'b0;
                     state  <= S_SCAN_DRAIN;
                  end else begin
                     cy <= cy + 16'd1;
                  end
               end else begin
                  cx <= cx + 16'd1;
               end
            end
            // Empty frames settle through COPY_DRAIN so both outcomes share one exit path.
            S_SCAN_DRAIN: begin
               if (hit_n) begin
                  state    <= S_COPY;
                  src_rd   <= 1'b1;
                  src_addr <= base_n + ADDR_W'(x0_n);
                  cx       <= x0_n;
                  cy       <= y0_n;
               end else begin
                  state <= S_COPY_DRAIN;
                  empty <= 1'b1;
               end
            end
            S_COPY: begin
               dst_wr   <= 1'b1;
               dst_addr <= dcnt;
               dcnt     <= dcnt + 1'b1;
               if (cx == box_x1) begin
                  cx       <= box_x0;
                  src_addr <= src_addr + W_A - ADDR_W'(box_x1) + ADDR_W'(box_x0);
                  if (cy == box_y1) begin
                     src_rd <= 1'b0;
                     state  <= S_COPY_DRAIN;
                  end else begin
                     cy <= cy + 16'd1;
                  end
               end else begin
                  cx       <= cx + 16'd1;
                  src_addr <= src_addr + 1'b1;
               end
            end
            S_COPY_DRAIN: begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
